// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared definitions for the PLL start-up sequencer.
//   - state encodings (2-bit, legacy-compatible constants)
//   - default parameter values for pll_sequencer
//   - cnt_width(): counter width helper that stays >= 1 bit for limit 1
package pll_seq_pkg;

  localparam int DEF_RST_CYCLES   = 16;
  localparam int DEF_LOCK_STABLE  = 1024;
  localparam int DEF_LOCK_TIMEOUT = 65536;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_RESET_PLL = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;

  // A counter that must reach limit-1 needs $clog2(limit) bits; a limit of 1
  // would give a zero-width vector, so clamp to one bit.
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for a single-bit asynchronous input.
//   clk   in  destination clock
//   rst_n in  asynchronous active-low reset, clears both flops
//   d     in  asynchronous input
//   q     out synchronized output (two clk edges of latency)
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/pll_sequencer.sv
// pll_sequencer: holds a PLL in reset, waits for a stable lock, then releases
// the system reset; any lock loss, lock timeout or relock request restarts
// the sequence.
//   clkin      in   reference clock, all logic runs here
//   rst_n      in   asynchronous active-low reset
//   locked     in   PLL lock flag (asynchronous, synchronized internally)
//   req_reset  in   synchronous single-cycle relock request
//   pll_rst    out  active-high reset to the PLL
//   sys_rst_n  out  active-low reset for logic on the PLL output clocks
//   ready      out  high only in RUN
//   state      out  current state encoding (see pll_seq_pkg)
//   relock_cnt out  saturating count of RESET_PLL re-entries
module pll_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       req_reset,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] relock_cnt
);

  localparam int RW = cnt_width(RST_CYCLES);
  localparam int SW = cnt_width(LOCK_STABLE);
  localparam int TW = cnt_width(LOCK_TIMEOUT);

  // Counters start at 0 on state entry, so the Nth cycle sees value N-1.
  localparam logic [RW-1:0] RST_LAST     = RW'(RST_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);

  logic          lock_s;

  logic [1:0]    state_reg;
  logic [1:0]    state_next;
  logic [RW-1:0] rst_cnt_reg;
  logic [RW-1:0] rst_cnt_next;
  logic [SW-1:0] stable_cnt_reg;
  logic [SW-1:0] stable_cnt_next;
  logic [TW-1:0] timeout_cnt_reg;
  logic [TW-1:0] timeout_cnt_next;
  logic          enter_rst;

  logic          pll_rst_reg;
  logic          sys_rst_n_reg;
  logic          ready_reg;
  logic [7:0]    relock_cnt_reg;

  sync2 u_lock_sync (
    .clk   (clkin),
    .rst_n (rst_n),
    .d     (locked),
    .q     (lock_s)
  );

  always_comb begin
    state_next       = state_reg;
    rst_cnt_next     = rst_cnt_reg;
    stable_cnt_next  = stable_cnt_reg;
    timeout_cnt_next = timeout_cnt_reg;
    enter_rst        = 1'b0;

    if (req_reset) begin
      // Relock request wins over everything, including a RESET_PLL in
      // progress (which therefore restarts its count).
      state_next = ST_RESET_PLL;
      enter_rst  = 1'b1;
    end else begin
      case (state_reg)
        ST_RESET_PLL: begin
          if (rst_cnt_reg == RST_LAST) begin
            state_next = ST_WAIT_LOCK;
          end else begin
            rst_cnt_next = rst_cnt_reg + RW'(1);
          end
        end
        ST_WAIT_LOCK: begin
          // Lock is tested first so a simultaneous timeout resolves to RUN.
          if (lock_s && (stable_cnt_reg == STABLE_LAST)) begin
            state_next = ST_RUN;
          end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
            state_next = ST_RESET_PLL;
            enter_rst  = 1'b1;
          end else begin
            stable_cnt_next  = lock_s ? (stable_cnt_reg + SW'(1)) : '0;
            timeout_cnt_next = timeout_cnt_reg + TW'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_next = ST_RESET_PLL;
            enter_rst  = 1'b1;
          end
        end
        default: begin
          // Encoding 3 is unreachable in normal operation; recover via reset.
          state_next = ST_RESET_PLL;
          enter_rst  = 1'b1;
        end
      endcase
    end

    // Every state entry (including a RESET_PLL restart) begins from zero.
    if ((state_next != state_reg) || enter_rst) begin
      rst_cnt_next     = '0;
      stable_cnt_next  = '0;
      timeout_cnt_next = '0;
    end
  end

  // Outputs are decoded from the next state so they switch on the very edge
  // that performs the transition, and stay registered.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_RESET_PLL;
      rst_cnt_reg     <= '0;
      stable_cnt_reg  <= '0;
      timeout_cnt_reg <= '0;
      pll_rst_reg     <= 1'b1;
      sys_rst_n_reg   <= 1'b0;
      ready_reg       <= 1'b0;
      relock_cnt_reg  <= 8'd0;
    end else begin
      state_reg       <= state_next;
      rst_cnt_reg     <= rst_cnt_next;
      stable_cnt_reg  <= stable_cnt_next;
      timeout_cnt_reg <= timeout_cnt_next;
      pll_rst_reg     <= (state_next == ST_RESET_PLL);
      sys_rst_n_reg   <= (state_next == ST_RUN);
      ready_reg       <= (state_next == ST_RUN);
      if (enter_rst && (relock_cnt_reg != 8'hFF)) begin
        relock_cnt_reg <= relock_cnt_reg + 8'd1;
      end
    end
  end

  assign pll_rst    = pll_rst_reg;
  assign sys_rst_n  = sys_rst_n_reg;
  assign ready      = ready_reg;
  assign state      = state_reg;
  assign relock_cnt = relock_cnt_reg;

endmodule

// File: tb/tb_pll_sequencer.sv
// tb_pll_sequencer: scoreboard bench for pll_sequencer with RST_CYCLES=4,
// LOCK_STABLE=8, LOCK_TIMEOUT=32. Each scenario task pushes the state
// transitions it expects (edge number, state, outputs, relock count); a
// monitor pops one entry per observed state change and compares it.
module tb_pll_sequencer;

  localparam int RSTC = 4;
  localparam int STAB = 8;
  localparam int TOUT = 32;

  localparam logic [1:0] S_RST  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic       clkin     = 1'b0;
  logic       rst_n     = 1'b0;
  logic       locked    = 1'b0;
  logic       req_reset = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic [1:0] state;
  logic [7:0] relock_cnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int exp_rc = 0;
  bit mon_en = 1'b0;
  logic [1:0] prev_state = 2'd0;

  typedef struct {
    int         edge_no;
    logic [1:0] st;
    logic       prst;
    logic       srstn;
    logic       rdy;
    logic [7:0] rc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_x;

  pll_sequencer #(
    .RST_CYCLES   (RSTC),
    .LOCK_STABLE  (STAB),
    .LOCK_TIMEOUT (TOUT)
  ) dut (
    .clkin      (clkin),
    .rst_n      (rst_n),
    .locked     (locked),
    .req_reset  (req_reset),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .state      (state),
    .relock_cnt (relock_cnt)
  );

  always #5 clkin = ~clkin;
  always @(posedge clkin) cyc++;

  // Output table per state: RESET_PLL holds the PLL, RUN releases the system.
  task automatic push_exp(input int e, input logic [1:0] st, input int rc);
    exp_t x;
    x.edge_no = e;
    x.st      = st;
    x.prst    = (st == S_RST);
    x.srstn   = (st == S_RUN);
    x.rdy     = (st == S_RUN);
    x.rc      = 8'(rc);
    exp_q.push_back(x);
  endtask

  always @(negedge clkin) begin
    if (mon_en && (state !== prev_state)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_txn: state %0d->%0d at edge %0d, required no transition",
                 prev_state, state, cyc);
      end else begin
        mon_x = exp_q.pop_front();
        $display("txn edge=%0d state=%0d pll_rst=%b sys_rst_n=%b ready=%b relock_cnt=%0d",
                 cyc, state, pll_rst, sys_rst_n, ready, relock_cnt);
        checks++;
        if (cyc !== mon_x.edge_no) begin
          errors++;
          $display("FAIL txn_edge: got edge %0d, required %0d (state %0d)", cyc, mon_x.edge_no, mon_x.st);
        end
        checks++;
        if (state !== mon_x.st) begin
          errors++;
          $display("FAIL txn_state: got %0d, required %0d", state, mon_x.st);
        end
        checks++;
        if (pll_rst !== mon_x.prst) begin
          errors++;
          $display("FAIL txn_pll_rst: got %b, required %b", pll_rst, mon_x.prst);
        end
        checks++;
        if (sys_rst_n !== mon_x.srstn) begin
          errors++;
          $display("FAIL txn_sys_rst_n: got %b, required %b", sys_rst_n, mon_x.srstn);
        end
        checks++;
        if (ready !== mon_x.rdy) begin
          errors++;
          $display("FAIL txn_ready: got %b, required %b", ready, mon_x.rdy);
        end
        checks++;
        if (relock_cnt !== mon_x.rc) begin
          errors++;
          $display("FAIL txn_relock_cnt: got %0d, required %0d", relock_cnt, mon_x.rc);
        end
      end
    end
    prev_state = state;
  end

  // Bounded wait for all expected transitions of a scenario.
  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clkin);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d transitions still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    int c;
    locked    = 1'b1;
    req_reset = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clkin);
    checks++;
    if (state !== S_RST) begin errors++; $display("FAIL reset_state: got %0d, required 0", state); end
    checks++;
    if (pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst: got %b, required 1", pll_rst); end
    checks++;
    if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL reset_sys_rst_n: got %b, required 0", sys_rst_n); end
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0", ready); end
    checks++;
    if (relock_cnt !== 8'd0) begin errors++; $display("FAIL reset_relock_cnt: got %0d, required 0", relock_cnt); end
    @(negedge clkin);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    c      = cyc;
    exp_rc = 0;
    push_exp(c + RSTC, S_WAIT, exp_rc);
    push_exp(c + RSTC + STAB, S_RUN, exp_rc);
    drain("reset", 40);
  endtask

  task automatic test_lock_loss();
    int c;
    @(negedge clkin);
    c      = cyc;
    locked = 1'b0;
    exp_rc++;
    // Two synchronizer edges, then the RUN state sees lock_s=0 on the third.
    push_exp(c + 3, S_RST, exp_rc);
    push_exp(c + 3 + RSTC, S_WAIT, exp_rc);
    push_exp(c + 3 + RSTC + STAB, S_RUN, exp_rc);
    @(negedge clkin);
    locked = 1'b1;
    drain("lock_loss", 40);
  endtask

  task automatic test_timeout();
    int c;
    @(negedge clkin);
    #1;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    locked = 1'b0;
    #1;
    // Asserted between edges while in RUN: must already be in reset.
    checks++;
    if (state !== S_RST) begin errors++; $display("FAIL async_run_state: got %0d, required 0", state); end
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL async_run_ready: got %b, required 0", ready); end
    repeat (2) @(negedge clkin);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    c      = cyc;
    exp_rc = 0;
    push_exp(c + RSTC, S_WAIT, 0);
    push_exp(c + RSTC + TOUT, S_RST, 1);
    push_exp(c + 2 * RSTC + TOUT, S_WAIT, 1);
    push_exp(c + 2 * RSTC + 2 * TOUT, S_RST, 2);
    push_exp(c + 3 * RSTC + 2 * TOUT, S_WAIT, 2);
    exp_rc = 2;
    drain("timeout", 100);
  endtask

  task automatic test_glitch();
    int c;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    locked = 1'b0;
    repeat (2) @(negedge clkin);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    c      = cyc;
    exp_rc = 0;
    // lock_s is high for WAIT edges c+6..c+10, low at c+11, then high:
    // the eight uninterrupted samples end at c+19.
    push_exp(c + RSTC, S_WAIT, 0);
    push_exp(c + 19, S_RUN, 0);
    repeat (3) @(negedge clkin);
    locked = 1'b1;
    repeat (5) @(negedge clkin);
    locked = 1'b0;
    @(negedge clkin);
    locked = 1'b1;
    repeat (4) @(negedge clkin);
    checks++;
    if (state !== S_WAIT) begin errors++; $display("FAIL glitch_still_waiting: got %0d, required 1", state); end
    drain("glitch", 40);
  endtask

  task automatic test_req_reset();
    int c;
    @(negedge clkin);
    c         = cyc;
    req_reset = 1'b1;
    exp_rc++;
    push_exp(c + 1, S_RST, exp_rc);
    @(negedge clkin);
    req_reset = 1'b0;
    @(negedge clkin);
    checks++;
    if (relock_cnt !== 8'(exp_rc)) begin errors++; $display("FAIL req_first_relock: got %0d, required %0d", relock_cnt, exp_rc); end
    req_reset = 1'b1;
    exp_rc++;
    @(negedge clkin);
    req_reset = 1'b0;
    checks++;
    if (relock_cnt !== 8'(exp_rc)) begin errors++; $display("FAIL req_second_relock: got %0d, required %0d", relock_cnt, exp_rc); end
    checks++;
    if (state !== S_RST) begin errors++; $display("FAIL req_mid_state: got %0d, required 0", state); end
    push_exp(c + 3 + RSTC, S_WAIT, exp_rc);
    push_exp(c + 3 + RSTC + STAB, S_RUN, exp_rc);
    repeat (3) @(negedge clkin);
    checks++;
    if (pll_rst !== 1'b1) begin errors++; $display("FAIL req_restart_pll_rst: got %b, required 1", pll_rst); end
    drain("req_reset", 40);
  endtask

  task automatic test_saturate();
    int p;
    p = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clkin);
      req_reset = 1'b1;
      if (exp_rc < 255) exp_rc++;
      if (i == 0) push_exp(cyc + 1, S_RST, exp_rc);
      @(negedge clkin);
      req_reset = 1'b0;
      p = cyc;
      if (i == 100) begin
        checks++;
        if (relock_cnt !== 8'(exp_rc)) begin errors++; $display("FAIL sat_mid_relock: got %0d, required %0d", relock_cnt, exp_rc); end
      end
    end
    checks++;
    if (relock_cnt !== 8'd255) begin errors++; $display("FAIL sat_relock: got %0d, required 255", relock_cnt); end
    push_exp(p + RSTC, S_WAIT, 255);
    push_exp(p + RSTC + STAB, S_RUN, 255);
    drain("saturate", 40);
    @(negedge clkin);
    #1;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    checks++;
    if (state !== S_RST) begin errors++; $display("FAIL async_state: got %0d, required 0", state); end
    checks++;
    if (pll_rst !== 1'b1) begin errors++; $display("FAIL async_pll_rst: got %b, required 1", pll_rst); end
    checks++;
    if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL async_sys_rst_n: got %b, required 0", sys_rst_n); end
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL async_ready: got %b, required 0", ready); end
    checks++;
    if (relock_cnt !== 8'd0) begin errors++; $display("FAIL async_relock_cnt: got %0d, required 0", relock_cnt); end
  endtask

  initial begin
    test_reset();
    test_lock_loss();
    test_timeout();
    test_glitch();
    test_req_reset();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pll_sequencer.md
PLL_SEQUENCER -- requirements
Module: pll_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: clkin cycles pll_rst is held high per reset attempt (min 1).
REQ-002 SHALL have parameter LOCK_STABLE, default 1024: consecutive synchronized locked-high cycles required before RUN (min 1).
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65536: maximum WAIT_LOCK cycles before retry; must exceed LOCK_STABLE.
REQ-004 SHALL have port clkin  in  1  reference clock; all logic in this domain.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port locked  in  1  PLL lock flag, asynchronous to clkin.
REQ-007 SHALL have port req_reset  in  1  synchronous relock request, single-cycle pulse.
REQ-008 SHALL have port pll_rst  out  1  active-high reset driven to the PLL.
REQ-009 SHALL have port sys_rst_n  out  1  active-low system reset for logic on PLL output clocks.
REQ-010 SHALL have port ready  out  1  high only in RUN.
REQ-011 SHALL have port state  out  2  current state encoding.
REQ-012 SHALL have port relock_cnt  out  8  saturating count of reset re-entries.

Function
REQ-013 SHALL pass locked through a two-flop synchronizer to form lock_s; only lock_s is used internally.
REQ-014 SHALL implement states RESET_PLL=0, WAIT_LOCK=1, RUN=2; encoding 3 is illegal and SHALL transition to RESET_PLL on the next edge.
REQ-015 RESET_PLL: pll_rst=1, sys_rst_n=0, ready=0; after exactly RST_CYCLES cycles in the state, SHALL go to WAIT_LOCK.
REQ-016 WAIT_LOCK: pll_rst=0, sys_rst_n=0; stable counter increments on each lock_s=1 cycle and clears on any lock_s=0 cycle.
REQ-017 WAIT_LOCK: when the stable counter reaches LOCK_STABLE, SHALL go to RUN on that edge.
REQ-018 WAIT_LOCK: when the timeout counter reaches LOCK_TIMEOUT without reaching RUN, SHALL go to RESET_PLL.
REQ-019 RUN: pll_rst=0, sys_rst_n=1, ready=1; any cycle with lock_s=0 SHALL cause transition to RESET_PLL.
REQ-020 req_reset=1 in any state SHALL force RESET_PLL on the next edge, with priority over every other transition; in RESET_PLL it restarts the RST_CYCLES count.
REQ-021 Every entry into RESET_PLL other than from reset SHALL increment relock_cnt, including timeout, lock loss and req_reset; it saturates at 255.
REQ-022 All outputs SHALL be registered and SHALL change only on the clkin edge that performs the state transition.
REQ-023 Counters SHALL be sized with $clog2 of their parameter and SHALL clear on every state entry.
REQ-024 Lock and timeout reaching the limit in the same cycle SHALL resolve to RUN.

Reset
REQ-025 rst_n low SHALL immediately and asynchronously set state=RESET_PLL, pll_rst=1, sys_rst_n=0, ready=0, relock_cnt=0, all counters and synchronizer flops=0.
REQ-026 rst_n assertion in any state, including RUN, SHALL take effect without waiting for a clock edge.
REQ-027 After rst_n deasserts, the RST_CYCLES count SHALL begin at the first clkin edge.

Structure
REQ-028 The state encodings SHALL live in shared package pll_seq_pkg.
REQ-029 The default parameter values SHALL also live in shared package pll_seq_pkg.
REQ-030 The two-flop synchronizer SHALL be a sub-module named sync2 with async active-low reset, reusable elsewhere.

Verification (RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32)
REQ-031 Release rst_n with locked tied high: pll_rst falls after 4 cycles, and sys_rst_n and ready rise 8 cycles after lock_s goes high; relock_cnt=0.
REQ-032 Keep locked low: after 32 WAIT_LOCK cycles the block re-enters RESET_PLL with pll_rst=1, and relock_cnt reaches 1, then 2 on the next timeout.
REQ-033 In WAIT_LOCK, toggle locked high 5 cycles, low 1 cycle, then high: RUN is reached only after 8 uninterrupted lock_s cycles.
REQ-034 In RUN, drop locked for 1 cycle: within 3 edges sys_rst_n=0, pll_rst=1, state=0 and relock_cnt increments; the block then recovers to RUN.
REQ-035 Pulse req_reset in RUN and again mid-RESET_PLL: the RESET_PLL count restarts so pll_rst stays high for 4 cycles after the second pulse, and relock_cnt increments by 2.
REQ-036 Force 300 re-entries, then assert rst_n low mid-RUN: relock_cnt saturates at 255, and all outputs reach their reset values with no clock edge applied.
